// File: rtl/set_assoc_cache_ctrl.sv
// -----------------------------------------------------------------------------
// set_assoc_cache_ctrl
//   Parametrised set-associative cache tag/state model for trace-driven cache
//   studies. Takes one read/write address per valid/ready handshake, looks up
//   the tag, and applies FIFO or LRU replacement together with either
//   write-back/write-allocate (WBWA) or write-through/no-allocate (WTNA).
//   Keeps saturating counts of reads, writes, read/write misses and writebacks.
//
//   Request flow: IDLE (accept) -> LOOKUP -> UPDATE -> RESP -> IDLE.
//   resp_valid pulses in RESP, the 3rd cycle after the accepting cycle.
//
// Ports
//   clk, reset                  single rising-edge clock, synchronous active-high reset
//   req_valid / req_ready       request handshake (ready only in IDLE)
//   req_write, req_addr         access type and byte address
//   replace_policy              0 = FIFO, 1 = LRU (sampled at accept)
//   write_policy                0 = WBWA, 1 = WTNA (sampled at accept)
//   resp_valid/hit/evict        result of the accepted request
//   num_*                       saturating statistics counters
//   miss_rate_pm, miss_rate_valid   only with CACHE_MISS_RATE_EN defined:
//                               per-mille miss rate from a serial divider
//
// Configuration macro: CACHE_MISS_RATE_EN
// -----------------------------------------------------------------------------
module set_assoc_cache_ctrl #(
  parameter int ADDR_W      = 48,
  parameter int BLOCK_BYTES = 64,
  parameter int NUM_SETS    = 64,
  parameter int WAYS        = 8,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              replace_policy,
  input  logic              write_policy,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_evict,
  output logic [CNT_W-1:0]  num_reads,
  output logic [CNT_W-1:0]  num_writes,
  output logic [CNT_W-1:0]  num_read_misses,
  output logic [CNT_W-1:0]  num_write_misses,
  output logic [CNT_W-1:0]  num_writebacks
`ifdef CACHE_MISS_RATE_EN
  ,
  output logic [9:0]        miss_rate_pm,
  output logic              miss_rate_valid
`endif
);

  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_UPDATE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != {CNT_W{1'b1}})) r = v + CNT_W'(1);
    else                             r = v;
    return r;
  endfunction

  // Line state storage, one row per set
  logic [WAYS-1:0]  valid_q [NUM_SETS];
  logic [WAYS-1:0]  dirty_q [NUM_SETS];
  logic [WAY_W-1:0] age_q   [NUM_SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [NUM_SETS][WAYS];

  // Control / request registers
  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;
  logic [IDX_W-1:0] req_idx_q, req_idx_d;
  logic             req_wr_q, req_wr_d;
  logic             lru_q, lru_d;
  logic             wtna_q, wtna_d;
  logic             lk_hit_q, lk_hit_d;
  logic [WAY_W-1:0] lk_way_q, lk_way_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_hit_q, resp_hit_d;
  logic             resp_evict_q, resp_evict_d;
  logic [CNT_W-1:0] reads_q, reads_d, writes_q, writes_d;
  logic [CNT_W-1:0] rmiss_q, rmiss_d, wmiss_q, wmiss_d, wb_q, wb_d;

  // Row of the set addressed by the in-flight request, and its next value
  logic [WAYS-1:0]  row_valid_s, row_dirty_s;
  logic [WAY_W-1:0] row_age_s [WAYS];
  logic [TAG_W-1:0] row_tag_s [WAYS];
  logic [WAYS-1:0]  row_valid_d, row_dirty_d;
  logic [WAY_W-1:0] row_age_d [WAYS];
  logic [TAG_W-1:0] row_tag_d [WAYS];

  logic             lk_hit_s, inv_any_s, evict_s, accept_s;
  logic [WAY_W-1:0] lk_hit_way_s, inv_way_s, old_way_s, lk_vic_way_s, hit_age_s;
  logic             unused_offset_s;

  assign unused_offset_s = ^req_addr[OFF_W-1:0];

  // Read out the addressed row
  always_comb begin
    row_valid_s = valid_q[req_idx_q];
    row_dirty_s = dirty_q[req_idx_q];
    for (int w = 0; w < WAYS; w++) begin
      row_age_s[w] = age_q[req_idx_q][w];
      row_tag_s[w] = tag_q[req_idx_q][w];
    end
  end

  // Tag match and victim choice; descending scan leaves the lowest matching index
  always_comb begin
    lk_hit_s     = 1'b0;
    lk_hit_way_s = {WAY_W{1'b0}};
    inv_any_s    = 1'b0;
    inv_way_s    = {WAY_W{1'b0}};
    old_way_s    = {WAY_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      lk_hit_s     = lk_hit_s | (row_valid_s[w] & (row_tag_s[w] == req_tag_q));
      lk_hit_way_s = (row_valid_s[w] && (row_tag_s[w] == req_tag_q)) ? WAY_W'(w) : lk_hit_way_s;
      inv_any_s    = inv_any_s | ~row_valid_s[w];
      inv_way_s    = row_valid_s[w] ? inv_way_s : WAY_W'(w);
      old_way_s    = (row_valid_s[w] && (row_age_s[w] == WAY_W'(WAYS - 1))) ? WAY_W'(w) : old_way_s;
    end
    lk_vic_way_s = inv_any_s ? inv_way_s : old_way_s;
  end

  // New row contents for the UPDATE cycle (lk_way_q is hit way or victim)
  always_comb begin
    row_valid_d = row_valid_s;
    row_dirty_d = row_dirty_s;
    for (int w = 0; w < WAYS; w++) begin
      row_age_d[w] = row_age_s[w];
      row_tag_d[w] = row_tag_s[w];
    end
    evict_s   = 1'b0;
    hit_age_s = row_age_s[lk_way_q];
    if (lk_hit_q) begin
      // LRU promotes the hit line; only lines younger than it age by one
      for (int w = 0; w < WAYS; w++) begin
        row_age_d[w] = (lru_q && row_valid_s[w] && (row_age_s[w] < hit_age_s))
                       ? row_age_s[w] + WAY_W'(1) : row_age_s[w];
      end
      row_age_d[lk_way_q]   = lru_q ? {WAY_W{1'b0}} : hit_age_s;
      row_dirty_d[lk_way_q] = row_dirty_s[lk_way_q] | (req_wr_q & ~wtna_q);
    end else if (!(req_wr_q && wtna_q)) begin
      // Allocate: victim becomes newest, every other valid line ages by one
      evict_s = row_valid_s[lk_way_q] & row_dirty_s[lk_way_q];
      for (int w = 0; w < WAYS; w++) begin
        row_age_d[w] = (row_valid_s[w] && (WAY_W'(w) != lk_way_q))
                       ? row_age_s[w] + WAY_W'(1) : row_age_s[w];
      end
      row_valid_d[lk_way_q] = 1'b1;
      row_dirty_d[lk_way_q] = req_wr_q;
      row_tag_d[lk_way_q]   = req_tag_q;
      row_age_d[lk_way_q]   = {WAY_W{1'b0}};
    end else begin
      evict_s = 1'b0;
    end
  end

  // Next state, request capture and response registers
  always_comb begin
    state_d      = state_q;
    accept_s     = 1'b0;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_evict_d = resp_evict_q;
    lk_hit_d     = lk_hit_q;
    lk_way_d     = lk_way_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          state_d  = S_LOOKUP;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_LOOKUP: begin
        lk_hit_d = lk_hit_s;
        lk_way_d = lk_hit_s ? lk_hit_way_s : lk_vic_way_s;
        state_d  = S_UPDATE;
      end
      S_UPDATE: begin
        resp_valid_d = 1'b1;
        resp_hit_d   = lk_hit_q;
        resp_evict_d = evict_s;
        state_d      = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d   = (state_d == S_IDLE);
    req_tag_d = accept_s ? req_addr[ADDR_W-1:OFF_W+IDX_W] : req_tag_q;
    req_idx_d = accept_s ? req_addr[OFF_W+IDX_W-1:OFF_W]  : req_idx_q;
    req_wr_d  = accept_s ? req_write      : req_wr_q;
    lru_d     = accept_s ? replace_policy : lru_q;
    wtna_d    = accept_s ? write_policy   : wtna_q;
  end

  // Statistics counters advance only in UPDATE
  always_comb begin
    if (state_q == S_UPDATE) begin
      reads_d  = sat_inc(reads_q,  ~req_wr_q);
      writes_d = sat_inc(writes_q,  req_wr_q);
      rmiss_d  = sat_inc(rmiss_q,  ~req_wr_q & ~lk_hit_q);
      wmiss_d  = sat_inc(wmiss_q,   req_wr_q & ~lk_hit_q);
      wb_d     = sat_inc(wb_q,      evict_s);
    end else begin
      reads_d  = reads_q;
      writes_d = writes_q;
      rmiss_d  = rmiss_q;
      wmiss_d  = wmiss_q;
      wb_d     = wb_q;
    end
  end

  // Control, request and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      req_tag_q    <= {TAG_W{1'b0}};
      req_idx_q    <= {IDX_W{1'b0}};
      req_wr_q     <= 1'b0;
      lru_q        <= 1'b0;
      wtna_q       <= 1'b0;
      lk_hit_q     <= 1'b0;
      lk_way_q     <= {WAY_W{1'b0}};
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_evict_q <= 1'b0;
      reads_q      <= {CNT_W{1'b0}};
      writes_q     <= {CNT_W{1'b0}};
      rmiss_q      <= {CNT_W{1'b0}};
      wmiss_q      <= {CNT_W{1'b0}};
      wb_q         <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      req_tag_q    <= req_tag_d;
      req_idx_q    <= req_idx_d;
      req_wr_q     <= req_wr_d;
      lru_q        <= lru_d;
      wtna_q       <= wtna_d;
      lk_hit_q     <= lk_hit_d;
      lk_way_q     <= lk_way_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_evict_q <= resp_evict_d;
      reads_q      <= reads_d;
      writes_q     <= writes_d;
      rmiss_q      <= rmiss_d;
      wmiss_q      <= wmiss_d;
      wb_q         <= wb_d;
    end
  end

  // Valid/dirty/age state: cleared by reset, row written back in UPDATE
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= {WAYS{1'b0}};
        dirty_q[s] <= {WAYS{1'b0}};
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= {WAY_W{1'b0}};
      end
    end else if (state_q == S_UPDATE) begin
      valid_q[req_idx_q] <= row_valid_d;
      dirty_q[req_idx_q] <= row_dirty_d;
      for (int w = 0; w < WAYS; w++) age_q[req_idx_q][w] <= row_age_d[w];
    end
  end

  // Tags need no reset; they are meaningless while the line is invalid
  always_ff @(posedge clk) begin
    if (state_q == S_UPDATE) begin
      for (int w = 0; w < WAYS; w++) tag_q[req_idx_q][w] <= row_tag_d[w];
    end
  end

  assign req_ready        = ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_hit         = resp_hit_q;
  assign resp_evict       = resp_evict_q;
  assign num_reads        = reads_q;
  assign num_writes       = writes_q;
  assign num_read_misses  = rmiss_q;
  assign num_write_misses = wmiss_q;
  assign num_writebacks   = wb_q;

`ifdef CACHE_MISS_RATE_EN
  // Misses can reach 2*(2^CNT_W-1), so misses*1000 needs CNT_W+11 bits. The
  // quotient never exceeds 1000, so its top bit is always zero: that bit is
  // preloaded into the remainder and only CNT_W+10 shift steps are run.
  localparam int DVD_W = CNT_W + 11;
  localparam int REM_W = CNT_W + 2;
  localparam int STEPS = CNT_W + 10;
  localparam int STP_W = $clog2(STEPS + 1);

  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W:0]   den_q, den_d;
  logic [STP_W-1:0] step_q, step_d;
  logic             busy_q, busy_d;
  logic [9:0]       pm_q, pm_d;
  logic             mr_valid_q, mr_valid_d;
  logic [DVD_W-1:0] num_s;
  logic [CNT_W:0]   tot_s;
  logic [REM_W-1:0] rem_sh_s;
  logic             qbit_s;

  // Divider: load on every RESP (restarting any divide), otherwise one step per cycle
  always_comb begin
    num_s      = DVD_W'({1'b0, rmiss_q} + {1'b0, wmiss_q}) * DVD_W'(1000);
    tot_s      = {1'b0, reads_q} + {1'b0, writes_q};
    rem_sh_s   = {rem_q[REM_W-2:0], dvd_q[DVD_W-1]};
    qbit_s     = (rem_sh_s >= REM_W'(den_q));
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    den_d      = den_q;
    step_d     = step_q;
    busy_d     = busy_q;
    pm_d       = pm_q;
    mr_valid_d = mr_valid_q;
    if (state_q == S_RESP) begin
      dvd_d  = {num_s[DVD_W-2:0], 1'b0};
      rem_d  = REM_W'(num_s[DVD_W-1]);
      den_d  = tot_s;
      step_d = STP_W'(STEPS);
      if (tot_s == {(CNT_W+1){1'b0}}) begin
        busy_d     = 1'b0;
        pm_d       = 10'd0;
        mr_valid_d = 1'b1;
      end else begin
        busy_d     = 1'b1;
        mr_valid_d = 1'b0;
      end
    end else if (busy_q) begin
      rem_d  = qbit_s ? (rem_sh_s - REM_W'(den_q)) : rem_sh_s;
      dvd_d  = {dvd_q[DVD_W-2:0], qbit_s};
      step_d = step_q - STP_W'(1);
      if (step_q == STP_W'(1)) begin
        busy_d     = 1'b0;
        pm_d       = dvd_d[9:0];
        mr_valid_d = 1'b1;
      end else begin
        busy_d     = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q      <= {DVD_W{1'b0}};
      rem_q      <= {REM_W{1'b0}};
      den_q      <= {(CNT_W+1){1'b0}};
      step_q     <= {STP_W{1'b0}};
      busy_q     <= 1'b0;
      pm_q       <= 10'd0;
      mr_valid_q <= 1'b0;
    end else begin
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      den_q      <= den_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      pm_q       <= pm_d;
      mr_valid_q <= mr_valid_d;
    end
  end

  assign miss_rate_pm    = pm_q;
  assign miss_rate_valid = mr_valid_q;
`endif

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Self-checking bench for set_assoc_cache_ctrl. The reference model keeps each
// set as a recency-ordered list of (tag, dirty) entries (position 0 = newest)
// and predicts hit/evict/counters for every accepted request.
module tb_set_assoc_cache_ctrl;
  localparam int ADDR_W      = 48;
  localparam int BLOCK_BYTES = 64;
  localparam int NUM_SETS    = 64;
  localparam int WAYS        = 8;
  localparam int CNT_W       = 32;
  localparam longint SPAN    = BLOCK_BYTES * NUM_SETS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              replace_policy = 1'b0;
  logic              write_policy = 1'b0;
  logic              resp_valid, resp_hit, resp_evict;
  logic [CNT_W-1:0]  num_reads, num_writes, num_read_misses, num_write_misses, num_writebacks;
`ifdef CACHE_MISS_RATE_EN
  logic [9:0]        miss_rate_pm;
  logic              miss_rate_valid;
`endif

  set_assoc_cache_ctrl #(
    .ADDR_W(ADDR_W), .BLOCK_BYTES(BLOCK_BYTES), .NUM_SETS(NUM_SETS), .WAYS(WAYS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .replace_policy(replace_policy),
    .write_policy(write_policy), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_evict(resp_evict), .num_reads(num_reads), .num_writes(num_writes),
    .num_read_misses(num_read_misses), .num_write_misses(num_write_misses),
    .num_writebacks(num_writebacks)
`ifdef CACHE_MISS_RATE_EN
    , .miss_rate_pm(miss_rate_pm), .miss_rate_valid(miss_rate_valid)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [ADDR_W-1:0] m_tag   [NUM_SETS][WAYS];
  bit                m_dirty [NUM_SETS][WAYS];
  int                m_cnt   [NUM_SETS];
  longint m_r, m_w, m_rm, m_wm, m_wb;

  typedef struct {
    bit     hit;
    bit     evict;
    longint r, w, rm, wm, wb;
    int     acc;
  } exp_t;
  exp_t exp_q[$];

  bit chk_en = 1'b0;
  bit last_hit, last_evict;

  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++) m_cnt[s] = 0;
    m_r = 0; m_w = 0; m_rm = 0; m_wm = 0; m_wb = 0;
  endtask

  task automatic model_access(input bit wr, input logic [ADDR_W-1:0] addr, input bit lru,
                              input bit wtna, output bit hit, output bit evict);
    int s;
    int pos;
    logic [ADDR_W-1:0] t;
    bit d;
    s     = int'((addr / BLOCK_BYTES) % NUM_SETS);
    t     = addr / SPAN;
    pos   = -1;
    hit   = 1'b0;
    evict = 1'b0;
    for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) pos = i;
    if (pos >= 0) begin
      hit = 1'b1;
      if (wr && !wtna) m_dirty[s][pos] = 1'b1;
      if (lru) begin
        d = m_dirty[s][pos];
        for (int i = pos; i > 0; i--) begin
          m_tag[s][i]   = m_tag[s][i-1];
          m_dirty[s][i] = m_dirty[s][i-1];
        end
        m_tag[s][0] = t; m_dirty[s][0] = d;
      end
    end else if (!(wr && wtna)) begin
      if (m_cnt[s] == WAYS) begin
        evict = m_dirty[s][WAYS-1];
        m_cnt[s] = WAYS - 1;
      end
      for (int i = m_cnt[s]; i > 0; i--) begin
        m_tag[s][i]   = m_tag[s][i-1];
        m_dirty[s][i] = m_dirty[s][i-1];
      end
      m_tag[s][0] = t; m_dirty[s][0] = wr;
      m_cnt[s]++;
    end
    if (wr) m_w++; else m_r++;
    if (!hit && wr)  m_wm++;
    if (!hit && !wr) m_rm++;
    if (evict) m_wb++;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_resp: got resp_valid 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("resp_latency", 64'(cyc - e.acc), 64'd3);
          chk("resp_hit",     64'(resp_hit),   64'(e.hit));
          chk("resp_evict",   64'(resp_evict), 64'(e.evict));
          chk("num_reads",        64'(num_reads),        64'(e.r));
          chk("num_writes",       64'(num_writes),       64'(e.w));
          chk("num_read_misses",  64'(num_read_misses),  64'(e.rm));
          chk("num_write_misses", 64'(num_write_misses), 64'(e.wm));
          chk("num_writebacks",   64'(num_writebacks),   64'(e.wb));
          last_hit   = resp_hit;
          last_evict = resp_evict;
        end
      end else if (exp_q.size() == 0) begin
        chk("idle_reads",  64'(num_reads),       64'(m_r));
        chk("idle_rmiss",  64'(num_read_misses), 64'(m_rm));
        chk("idle_wmiss",  64'(num_write_misses), 64'(m_wm));
        chk("idle_wb",     64'(num_writebacks),  64'(m_wb));
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic access(input bit wr, input logic [ADDR_W-1:0] addr, input bit lru, input bit wtna);
    int t;
    exp_t e;
    bit h, ev;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    replace_policy = lru; write_policy = wtna;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1 (cycle %0d)", cyc);
      req_valid = 1'b0;
      return;
    end
    model_access(wr, addr, lru, wtna, h, ev);
    e.hit = h; e.evict = ev; e.r = m_r; e.w = m_w; e.rm = m_rm; e.wm = m_wm; e.wb = m_wb;
    e.acc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 10) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout: got no resp_valid expected one (cycle %0d)", cyc);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    chk("rst_req_ready",  64'(req_ready),  64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_counters",   64'(num_reads | num_writes | num_read_misses | num_write_misses | num_writebacks), 64'd0);
    chk_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    model_reset();
    // 1. reset
    do_reset();

    // 2. read 0x1000 twice
    access(1'b0, 48'h1000, 1'b1, 1'b0);
    chk("t2_first_hit", 64'(last_hit), 64'd0);
    access(1'b0, 48'h1000, 1'b1, 1'b0);
    chk("t2_second_hit", 64'(last_hit), 64'd1);
    @(negedge clk);
    chk("t2_num_reads", 64'(num_reads), 64'd2);
    chk("t2_num_rmiss", 64'(num_read_misses), 64'd1);

    // 3a. LRU: tags 0..7, re-read 0, read 8 -> tag 1 evicted
    do_reset();
    for (int k = 0; k < 8; k++) access(1'b0, 48'(k * SPAN), 1'b1, 1'b0);
    access(1'b0, 48'h0, 1'b1, 1'b0);
    chk("t3_lru_rehit", 64'(last_hit), 64'd1);
    access(1'b0, 48'(8 * SPAN), 1'b1, 1'b0);
    access(1'b0, 48'h0, 1'b1, 1'b0);
    chk("t3_lru_tag0_hit", 64'(last_hit), 64'd1);
    access(1'b0, 48'(1 * SPAN), 1'b1, 1'b0);
    chk("t3_lru_tag1_miss", 64'(last_hit), 64'd0);

    // 3b. FIFO: same sequence -> tag 0 evicted
    do_reset();
    for (int k = 0; k < 8; k++) access(1'b0, 48'(k * SPAN), 1'b0, 1'b0);
    access(1'b0, 48'h0, 1'b0, 1'b0);
    chk("t3_fifo_rehit", 64'(last_hit), 64'd1);
    access(1'b0, 48'(8 * SPAN), 1'b0, 1'b0);
    access(1'b0, 48'h0, 1'b0, 1'b0);
    chk("t3_fifo_tag0_miss", 64'(last_hit), 64'd0);

    // 4a. WBWA dirty line evicted by conflicting reads
    do_reset();
    access(1'b1, 48'h0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) access(1'b0, 48'(k * SPAN), 1'b1, 1'b0);
    chk("t4_evict", 64'(last_evict), 64'd1);
    @(negedge clk);
    chk("t4_num_wb", 64'(num_writebacks), 64'd1);

    // 4b. WTNA write miss does not allocate
    do_reset();
    access(1'b1, 48'h0, 1'b0, 1'b1);
    access(1'b0, 48'h0, 1'b0, 1'b1);
    chk("t4_wtna_read_miss", 64'(last_hit), 64'd0);
    @(negedge clk);
    chk("t4_num_wmiss", 64'(num_write_misses), 64'd1);

    // Mixed directed traffic across three sets, alternating policies
    do_reset();
    for (int i = 0; i < 48; i++) begin
      access((i % 3) == 0, 48'(((i * 7) % 12) * SPAN + (i % 3) * BLOCK_BYTES + (i % 5) * 8),
             (i % 4) < 2, (i % 5) == 4);
    end

    // 5. reset during UPDATE aborts the request
    chk_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 48'h40; replace_policy = 1'b1; write_policy = 1'b0;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    chk("t5_ready", 64'(req_ready), 64'd1);
    @(negedge clk);            // LOOKUP
    req_valid = 1'b0;
    @(negedge clk);            // UPDATE
    reset = 1'b1;
    @(negedge clk);
    chk("t5_no_resp", 64'(resp_valid), 64'd0);
    chk("t5_counters", 64'(num_reads | num_writes | num_read_misses | num_write_misses | num_writebacks), 64'd0);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    chk("t5_idle_ready", 64'(req_ready), 64'd1);
    chk_en = 1'b1;
    access(1'b0, 48'h40, 1'b1, 1'b0);
    chk("t5_after_miss", 64'(last_hit), 64'd0);

`ifdef CACHE_MISS_RATE_EN
    // 6. miss rate: 4 accesses, 1 miss -> 250 per mille
    do_reset();
    chk("t6_rst_pm",    64'(miss_rate_pm),    64'd0);
    chk("t6_rst_valid", 64'(miss_rate_valid), 64'd0);
    for (int k = 0; k < 4; k++) access(1'b0, 48'h80, 1'b1, 1'b0);
    t = 0;
    @(negedge clk);
    while (!miss_rate_valid && t < CNT_W + 12) begin @(negedge clk); t++; end
    chk("t6_valid", 64'(miss_rate_valid), 64'd1);
    chk("t6_pm",    64'(miss_rate_pm),    64'd250);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
